frame_bank_buffer: RTL and testbench

FRAME_BANK_BUFFER -- requirements
Module: frame_bank_buffer

---
 rtl/frame_bank_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_frame_bank_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_buffer.sv
`default_nettype none
// ============================================================================
// frame_bank_buffer : banked frame store; the writer fills FREE banks and the
// reader consumes COMMITTED banks in commit order.        Rev 1.0
// ============================================================================
module frame_bank_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1500,
    parameter int BANKS  = 2,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [AW-1:0]     out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_len,
    output logic              out_valid,
    output logic              out_doorbell,
    input  logic              out_release,
    output logic              overflow,
    output logic [15:0]       drop_count
);
    localparam int          BW      = $clog2(BANKS);
    localparam int          CW      = $clog2(BANKS + 1);
    localparam int          MW      = $clog2(BANKS * DEPTH);
    localparam logic [15:0] DEPTH_C = 16'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;
    typedef enum logic       {R_EMPTY, R_HOLD} rstate_t;
    typedef enum logic [1:0] {B_FREE, B_FILLING, B_COMMITTED} bstate_t;

    wstate_t       wstate_q, wstate_d;
    rstate_t       rstate_q, rstate_d;
    bstate_t       bstate_q [BANKS];
    bstate_t       bstate_d [BANKS];
    logic [15:0]   len_q    [BANKS];
    logic [15:0]   len_d    [BANKS];
    logic [BW-1:0] qbank_q  [BANKS];
    logic [BW-1:0] qbank_d  [BANKS];
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [15:0]   count_q, count_d;
    logic [BW-1:0] fill_q, fill_d;
    logic          doorbell_q, doorbell_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;

    logic [DATA_W-1:0] mem [BANKS*DEPTH];
    logic [DATA_W-1:0] rdata_q;

    logic          wr_en;
    logic [BW-1:0] wr_bank;
    logic [15:0]   wr_off;
    logic [MW-1:0] wr_addr, rd_addr;
    logic          any_free;
    logic [BW-1:0] free_idx;
    logic          accept, claim, commit, drop, release_ok;
    logic [BW-1:0] commit_bank;
    logic [15:0]   commit_len;
    logic [BW-1:0] head;

    // Lowest-index FREE bank wins the claim.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (bstate_q[i] == B_FREE) begin
                any_free = 1'b1;
                free_idx = BW'(i);
            end
        end
    end

    assign head     = qbank_q[0];
    assign in_ready = !sys_rst && ((wstate_q != W_IDLE) || any_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        wstate_d    = wstate_q;
        count_d     = count_q;
        fill_d      = fill_q;
        wr_en       = 1'b0;
        wr_bank     = fill_q;
        wr_off      = count_q;
        claim       = 1'b0;
        commit      = 1'b0;
        commit_bank = fill_q;
        commit_len  = count_q + 16'd1;
        drop        = 1'b0;
        case (wstate_q)
            W_IDLE: if (accept) begin
                wr_en   = 1'b1;
                wr_bank = free_idx;
                wr_off  = '0;
                if (in_last) begin
                    commit      = 1'b1;
                    commit_bank = free_idx;
                    commit_len  = 16'd1;
                end else begin
                    claim    = 1'b1;
                    fill_d   = free_idx;
                    count_d  = 16'd1;
                    wstate_d = W_FILL;
                end
            end
            W_FILL: if (accept) begin
                if (count_q == DEPTH_C) begin
                    drop     = 1'b1;
                    wstate_d = in_last ? W_IDLE : W_DISCARD;
                end else begin
                    wr_en = 1'b1;
                    if (in_last) begin
                        commit   = 1'b1;
                        wstate_d = W_IDLE;
                    end else begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            W_DISCARD: if (accept && in_last) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    assign overflow_d = drop;
    assign drop_d     = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

    // Release pops before commit pushes, so a same-cycle pair lands the new
    // frame directly at the head and the reader stays in R_HOLD.
    always_comb begin
        bstate_d   = bstate_q;
        len_d      = len_q;
        qbank_d    = qbank_q;
        qcnt_d     = qcnt_q;
        rstate_d   = rstate_q;
        doorbell_d = 1'b0;
        release_ok = (rstate_q == R_HOLD) && out_release;
        if (claim) bstate_d[free_idx] = B_FILLING;
        if (drop)  bstate_d[fill_q]   = B_FREE;
        if (commit) begin
            bstate_d[commit_bank] = B_COMMITTED;
            len_d[commit_bank]    = commit_len;
        end
        if (release_ok) begin
            bstate_d[head] = B_FREE;
            for (int i = 0; i < BANKS - 1; i++) qbank_d[i] = qbank_q[i+1];
            qcnt_d = qcnt_q - CW'(1);
        end
        if (commit) begin
            for (int i = 0; i < BANKS; i++) begin
                if (qcnt_d == CW'(i)) qbank_d[i] = commit_bank;
            end
            qcnt_d = qcnt_d + CW'(1);
        end
        case (rstate_q)
            R_EMPTY: if (qcnt_q != '0) begin
                rstate_d   = R_HOLD;
                doorbell_d = 1'b1;
            end
            R_HOLD: if (release_ok) begin
                if (qcnt_d != '0) doorbell_d = 1'b1;
                else              rstate_d   = R_EMPTY;
            end
            default: rstate_d = R_EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_EMPTY;
            qcnt_q     <= '0;
            count_q    <= '0;
            fill_q     <= '0;
            doorbell_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            for (int i = 0; i < BANKS; i++) begin
                bstate_q[i] <= B_FREE;
                len_q[i]    <= '0;
                qbank_q[i]  <= '0;
            end
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            qcnt_q     <= qcnt_d;
            count_q    <= count_d;
            fill_q     <= fill_d;
            doorbell_q <= doorbell_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            bstate_q   <= bstate_d;
            len_q      <= len_d;
            qbank_q    <= qbank_d;
        end
    end

    assign wr_addr = MW'(wr_bank) * MW'(DEPTH) + MW'(wr_off);
    assign rd_addr = MW'(head) * MW'(DEPTH) + MW'(out_addr);

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_addr] <= in_data;
        rdata_q <= mem[rd_addr];
    end

    assign out_data     = rdata_q;
    assign out_valid    = (rstate_q == R_HOLD);
    assign out_len      = out_valid ? len_q[head] : 16'd0;
    assign out_doorbell = doorbell_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_buffer.sv
`default_nettype none
// ============================================================================
// tb_frame_bank_buffer : directed steps with random payloads, checked against
// a frame-queue reference model.                          Rev 1.0
// ============================================================================
module tb_frame_bank_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int BANKS  = 2;
    localparam int AW     = $clog2(DEPTH);

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [AW-1:0]     out_addr;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       out_len;
    logic              out_valid;
    logic              out_doorbell;
    logic              out_release;
    logic              overflow;
    logic [15:0]       drop_count;

    always #5 sys_clk = ~sys_clk;

    frame_bank_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BANKS(BANKS), .AW(AW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_addr(out_addr), .out_data(out_data), .out_len(out_len),
        .out_valid(out_valid), .out_doorbell(out_doorbell), .out_release(out_release),
        .overflow(overflow), .drop_count(drop_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: committed frames in commit order, plus the drop tally.
    logic [127:0] mdata_q[$];
    int           mlen_q[$];
    int           mdrops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [127:0] d, input bit rel_last);
        for (int i = 0; i < n; i++) begin
            in_valid    = 1'b1;
            in_data     = d[i*8 +: 8];
            in_last     = (i == n - 1);
            out_release = rel_last && (i == n - 1);
            chk("in_ready_word", in_ready, 1);
            step();
            chk("overflow_word", overflow, (i == DEPTH));
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_release = 1'b0;
        if (rel_last) begin
            mdata_q.delete(0);
            mlen_q.delete(0);
        end
        if (n > DEPTH) begin
            mdrops++;
        end else begin
            mdata_q.push_back(d);
            mlen_q.push_back(n);
        end
        chk("drop_count", drop_count, mdrops);
    endtask

    task automatic check_new_head();
        chk("valid_before_doorbell", out_valid, 0);
        step();
        chk("doorbell_pulse", out_doorbell, 1);
        chk("valid_on_doorbell", out_valid, 1);
        chk("len_on_doorbell", out_len, mlen_q[0]);
        step();
        chk("doorbell_single", out_doorbell, 0);
    endtask

    task automatic read_head();
        logic [127:0] h;
        int           n;
        h = mdata_q[0];
        n = mlen_q[0];
        chk("head_valid", out_valid, 1);
        chk("head_len", out_len, n);
        for (int a = 0; a < n; a++) begin
            out_addr = AW'(a);
            step();
            chk("read_data", out_data, h[a*8 +: 8]);
        end
    endtask

    task automatic release_head();
        out_release = 1'b1;
        step();
        out_release = 1'b0;
        mdata_q.delete(0);
        mlen_q.delete(0);
        chk("valid_after_release", out_valid, mlen_q.size() > 0);
        chk("doorbell_after_release", out_doorbell, mlen_q.size() > 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d1, d2, d3;
        int           n1, n2, n3;

        sys_rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_addr = '0; out_release = 1'b0;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_doorbell", out_doorbell, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_drop_count", drop_count, 0);
        sys_rst = 1'b0;
        #1;
        chk("first_cycle_in_ready", in_ready, 1);

        // Known 4-word frame
        send_frame(4, 128'hEFBEADDE, 1'b0);
        check_new_head();
        read_head();
        release_head();

        // Random frames including the 1-word and full-DEPTH boundaries
        for (int k = 0; k < 6; k++) begin
            n1 = (k == 0) ? 1 : (k == 1) ? DEPTH : int'($urandom_range(1, DEPTH));
            d1 = {$urandom, $urandom, $urandom, $urandom};
            send_frame(n1, d1, 1'b0);
            check_new_head();
            if (n1 < DEPTH) begin
                out_addr = AW'(n1);
                step();
                chk("oor_valid", out_valid, 1);
                chk("oor_len", out_len, n1);
                chk("oor_doorbell", out_doorbell, 0);
            end
            read_head();
            release_head();
        end

        // Stray release while empty
        out_release = 1'b1;
        step();
        out_release = 1'b0;
        chk("stray_valid", out_valid, 0);
        step();
        chk("stray_doorbell", out_doorbell, 0);
        chk("stray_in_ready", in_ready, 1);

        // Bank exhaustion and in-order delivery
        n1 = $urandom_range(2, DEPTH); d1 = {$urandom, $urandom, $urandom, $urandom};
        n2 = $urandom_range(2, DEPTH); d2 = {$urandom, $urandom, $urandom, $urandom};
        n3 = $urandom_range(2, DEPTH); d3 = {$urandom, $urandom, $urandom, $urandom};
        send_frame(n1, d1, 1'b0);
        check_new_head();
        send_frame(n2, d2, 1'b0);
        chk("exhaust_no_doorbell", out_doorbell, 0);
        in_valid = 1'b1; in_data = d3[7:0]; in_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("exhaust_in_ready", in_ready, 0);
            step();
            chk("exhaust_no_overflow", overflow, 0);
        end
        in_valid = 1'b0;
        read_head();
        release_head();
        chk("exhaust_freed_ready", in_ready, 1);
        send_frame(n3, d3, 1'b0);
        read_head();
        release_head();
        read_head();
        release_head();

        // Overflow: last on word DEPTH+1, then overflow followed by discard
        d1 = {$urandom, $urandom, $urandom, $urandom};
        send_frame(DEPTH + 1, d1, 1'b0);
        step();
        chk("ovf_pulse_end", overflow, 0);
        chk("ovf_no_valid", out_valid, 0);
        chk("ovf_no_doorbell", out_doorbell, 0);
        d1 = {$urandom, $urandom, $urandom, $urandom};
        send_frame(DEPTH + 3, d1, 1'b0);
        step();
        chk("discard_no_valid", out_valid, 0);
        d1 = {$urandom, $urandom, $urandom, $urandom};
        send_frame(DEPTH, d1, 1'b0);
        check_new_head();
        read_head();
        release_head();

        // Same-cycle commit and release, for 1-word and multi-word commits
        for (int k = 0; k < 2; k++) begin
            n1 = $urandom_range(1, DEPTH); d1 = {$urandom, $urandom, $urandom, $urandom};
            n2 = (k == 0) ? 1 : int'($urandom_range(2, DEPTH));
            d2 = {$urandom, $urandom, $urandom, $urandom};
            send_frame(n1, d1, 1'b0);
            check_new_head();
            read_head();
            send_frame(n2, d2, 1'b1);
            chk("same_valid", out_valid, 1);
            chk("same_doorbell", out_doorbell, 1);
            chk("same_len", out_len, n2);
            chk("same_freed_ready", in_ready, 1);
            step();
            chk("same_doorbell_single", out_doorbell, 0);
            read_head();
            release_head();
        end

        // Reset with one bank held and another mid-fill
        n1 = $urandom_range(1, DEPTH); d1 = {$urandom, $urandom, $urandom, $urandom};
        send_frame(n1, d1, 1'b0);
        check_new_head();
        in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        sys_rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        step();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_drop_count", drop_count, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_doorbell", out_doorbell, 0);
        sys_rst = 1'b0;
        mdata_q.delete();
        mlen_q.delete();
        mdrops = 0;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        d1 = {$urandom, $urandom, $urandom, $urandom};
        send_frame(1, d1, 1'b0);
        check_new_head();
        read_head();
        release_head();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
